// File: rtl/nfsr_pkg.sv
// Shared definitions for the 80-bit Grain-80 style NFSR.
//   NFSR_WIDTH    : state width (tap set is only defined for 80)
//   Tap*          : bit indices used by the feedback function
//   nfsr_feedback : feedback bit g(b), computed from the pre-shift state
package nfsr_pkg;

  localparam int unsigned NFSR_WIDTH = 80;

  localparam int unsigned Tap0  = 0;
  localparam int unsigned Tap9  = 9;
  localparam int unsigned Tap14 = 14;
  localparam int unsigned Tap15 = 15;
  localparam int unsigned Tap21 = 21;
  localparam int unsigned Tap28 = 28;
  localparam int unsigned Tap33 = 33;
  localparam int unsigned Tap37 = 37;
  localparam int unsigned Tap45 = 45;
  localparam int unsigned Tap52 = 52;
  localparam int unsigned Tap60 = 60;
  localparam int unsigned Tap62 = 62;
  localparam int unsigned Tap63 = 63;

  function automatic logic nfsr_feedback(logic [NFSR_WIDTH-1:0] b);
    logic lin;
    logic nl;
    lin = b[Tap62] ^ b[Tap60] ^ b[Tap52] ^ b[Tap45] ^ b[Tap37] ^ b[Tap33] ^
          b[Tap28] ^ b[Tap21] ^ b[Tap14] ^ b[Tap9]  ^ b[Tap0];
    nl  = (b[Tap63] & b[Tap60]) ^
          (b[Tap37] & b[Tap33]) ^
          (b[Tap15] & b[Tap9]) ^
          (b[Tap60] & b[Tap52] & b[Tap45]) ^
          (b[Tap33] & b[Tap28] & b[Tap21]) ^
          (b[Tap63] & b[Tap45] & b[Tap28] & b[Tap9]) ^
          (b[Tap60] & b[Tap52] & b[Tap37] & b[Tap33]) ^
          (b[Tap63] & b[Tap60] & b[Tap21] & b[Tap15]) ^
          (b[Tap63] & b[Tap60] & b[Tap52] & b[Tap45] & b[Tap37]) ^
          (b[Tap33] & b[Tap28] & b[Tap21] & b[Tap15] & b[Tap9]) ^
          (b[Tap52] & b[Tap45] & b[Tap37] & b[Tap33] & b[Tap28] & b[Tap21]);
    return lin ^ nl;
  endfunction

endpackage

// File: rtl/nfsr_feedback_logic.sv
// Pure combinational NFSR feedback.
//   state_i : current register state b[79:0]
//   g_o     : feedback bit that enters b[79] on the next shift
module nfsr_feedback_logic
  import nfsr_pkg::*;
(
  input  logic [NFSR_WIDTH-1:0] state_i,
  output logic                  g_o
);

  always_comb begin
    g_o = nfsr_feedback(state_i);
  end

endmodule

// File: rtl/nfsr.sv
// 80-bit nonlinear feedback shift register with parallel load.
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset (clears the state)
//   shift_en : shift right one bit, feedback enters at the MSB
//   Par_load : load Seed (wins over shift_en)
//   Seed     : parallel load value
//   Par_out  : full state, straight from the register
//   Ser_out  : b[0], the bit leaving on the next enabled shift
module nfsr
  import nfsr_pkg::*;
#(
  parameter int unsigned WIDTH = NFSR_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             Par_load,
  input  logic [WIDTH-1:0] Seed,
  output logic [WIDTH-1:0] Par_out,
  output logic             Ser_out
);

  logic [WIDTH-1:0] state_q, state_d;
  logic             g;

  nfsr_feedback_logic u_feedback (
    .state_i (state_q),
    .g_o     (g)
  );

  // Priority: reset, load, shift, hold.
  always_comb begin
    state_d = state_q;
    if (rst) begin
      state_d = '0;
    end else if (Par_load) begin
      state_d = Seed;
    end else if (shift_en) begin
      state_d = {g, state_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
  end

  assign Par_out = state_q;
  assign Ser_out = state_q[0];

endmodule

// File: tb/tb_nfsr.sv
module tb_nfsr;

  logic        clk;
  logic        rst;
  logic        shift_en;
  logic        Par_load;
  logic [79:0] Seed;
  logic [79:0] Par_out;
  logic        Ser_out;

  int unsigned n_pass;
  int unsigned n_total;

  logic [79:0] model;

  nfsr dut (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .Par_load (Par_load),
    .Seed     (Seed),
    .Par_out  (Par_out),
    .Ser_out  (Ser_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference feedback: XOR of the listed linear taps and monomials (-1 = unused slot).
  int lin_taps [11] = '{62, 60, 52, 45, 37, 33, 28, 21, 14, 9, 0};
  int monos [11][6] = '{
    '{63, 60, -1, -1, -1, -1},
    '{37, 33, -1, -1, -1, -1},
    '{15,  9, -1, -1, -1, -1},
    '{60, 52, 45, -1, -1, -1},
    '{33, 28, 21, -1, -1, -1},
    '{63, 45, 28,  9, -1, -1},
    '{60, 52, 37, 33, -1, -1},
    '{63, 60, 21, 15, -1, -1},
    '{63, 60, 52, 45, 37, -1},
    '{33, 28, 21, 15,  9, -1},
    '{52, 45, 37, 33, 28, 21}
  };

  function automatic logic ref_g(logic [79:0] s);
    int acc;
    int prod;
    acc = 0;
    foreach (lin_taps[i]) acc += int'(s[lin_taps[i]]);
    for (int m = 0; m < 11; m++) begin
      prod = 1;
      for (int j = 0; j < 6; j++) begin
        if (monos[m][j] >= 0) prod = prod * int'(s[monos[m][j]]);
      end
      acc += prod;
    end
    return logic'(acc % 2);
  endfunction

  function automatic logic [79:0] ref_next(logic [79:0] s, logic r, logic pl, logic se,
                                           logic [79:0] sd);
    if (r) return 80'h0;
    if (pl) return sd;
    if (se) return {ref_g(s), s[79:1]};
    return s;
  endfunction

  task automatic check(input string name, input logic [79:0] exp);
    n_total++;
    if (Par_out === exp && Ser_out === exp[0]) begin
      n_pass++;
    end else begin
      $display("FAIL %s: Par_out=%h Ser_out=%b, expected Par_out=%h Ser_out=%b",
               name, Par_out, Ser_out, exp, exp[0]);
    end
  endtask

  // Apply inputs for one edge, sample #1 after it, keep the model in step.
  task automatic step(input logic r, input logic pl, input logic se, input logic [79:0] sd);
    rst      = r;
    Par_load = pl;
    shift_en = se;
    Seed     = sd;
    @(posedge clk);
    #1;
    model = ref_next(model, r, pl, se, sd);
    rst      = 1'b0;
    Par_load = 1'b0;
    shift_en = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic        r;
    logic        pl;
    logic        se;
    logic [79:0] seed;
    logic [79:0] exp;
  } vec_t;

  vec_t vecs [14];
  logic [79:0] rnd_seed;

  initial begin
    n_pass   = 0;
    n_total  = 0;
    model    = 80'h0;
    rst      = 1'b0;
    Par_load = 1'b0;
    shift_en = 1'b0;
    Seed     = 80'h0;

    // Reset after a load, then the all-zero fixed point under shifting.
    step(1'b0, 1'b1, 1'b0, 80'h123456789ABCDEF01234);
    step(1'b1, 1'b0, 1'b0, 80'h0);
    check("reset", 80'h0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b1, 80'h0);
      check("zero_fixed_point", 80'h0);
    end

    vecs[0]  = '{"load_1",       0, 1, 0, 80'h1, 80'h1};
    vecs[1]  = '{"shift_b0",     0, 0, 1, 80'h0, 80'h80000000000000000000};
    vecs[2]  = '{"shift_b79",    0, 0, 1, 80'h0, 80'h40000000000000000000};
    vecs[3]  = '{"load_200",     0, 1, 0, 80'h200, 80'h200};
    vecs[4]  = '{"shift_b9",     0, 0, 1, 80'h0, 80'h80000000000000000100};
    vecs[5]  = '{"load_63_60",   0, 1, 0, 80'h00009000000000000000, 80'h00009000000000000000};
    vecs[6]  = '{"nl_cancel",    0, 0, 1, 80'h0, 80'h00004800000000000000};
    vecs[7]  = '{"load_over_sh", 0, 1, 1, 80'hABCDEF0123456789FEDC, 80'hABCDEF0123456789FEDC};
    vecs[8]  = '{"hold_1",       0, 0, 0, 80'h0, 80'hABCDEF0123456789FEDC};
    vecs[9]  = '{"hold_2",       0, 0, 0, 80'h0, 80'hABCDEF0123456789FEDC};
    vecs[10] = '{"rst_over_load",1, 1, 1, 80'hFFFFFFFFFFFFFFFFFFFF, 80'h0};
    vecs[11] = '{"load_ones",    0, 1, 0, 80'hFFFFFFFFFFFFFFFFFFFF, 80'hFFFFFFFFFFFFFFFFFFFF};
    vecs[12] = '{"rst_mid",      1, 0, 1, 80'h0, 80'h0};
    vecs[13] = '{"after_rst",    0, 0, 1, 80'h0, 80'h0};

    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].pl, vecs[i].se, vecs[i].seed);
      check(vecs[i].name, vecs[i].exp);
    end

    // Long run with a pause, cycle by cycle against the model.
    step(1'b0, 1'b1, 1'b0, 80'h123456789ABCDEF01234);
    check("long_load", model);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b1, 80'h0);
      check("long_shift_a", model);
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 1'b0, 80'h0);
      check("long_pause", model);
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b1, 80'h0);
      check("long_shift_b", model);
    end

    // Randomized control and seeds against the model.
    for (int i = 0; i < 400; i++) begin
      rnd_seed = {$urandom(), $urandom(), 16'($urandom())};
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 1)), rnd_seed);
      check("random", model);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/nfsr.md
Name: nfsr

Overview:
- 80-bit nonlinear feedback shift register (Grain-80 style NFSR core, no external LFSR input).
- Parallel-loadable from a seed. Shifts right one bit per enabled clock; the nonlinear feedback enters at the MSB.
- Exposes the full state in parallel and the LSB as the serial keystream bit.
- Sits as the nonlinear state element of a stream-cipher / PRNG datapath.

Parameters:
- WIDTH, 80, state width. The tap set below is defined for 80 only; other values are unsupported.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- shift_en  in  1  advance the register one step this cycle
- Par_load  in  1  load Seed into the state this cycle
- Seed  in  80  parallel load value
- Par_out  out  80  current state b[79:0]
- Ser_out  out  1  serial output, equal to b[0]

Behaviour:
- One clock; reset is synchronous and active-high (clk, rst).
- State register b[79:0]; all updates occur on the rising edge of clk only.
- Per-edge priority: rst, then Par_load, then shift_en, then hold.
  - rst=1: b <= 80'h0.
  - else Par_load=1: b <= Seed. This happens even if shift_en=1; no shift occurs that cycle.
  - else shift_en=1: b[78:0] <= b[79:1]; b[79] <= g(b).
  - else: b holds.
- Feedback g(b), XOR of the following terms (no constant term):
  - Linear terms: b62, b60, b52, b45, b37, b33, b28, b21, b14, b9, b0
  - Nonlinear terms:
    - b63·b60, b37·b33, b15·b9
    - b60·b52·b45, b33·b28·b21
    - b63·b45·b28·b9, b60·b52·b37·b33, b63·b60·b21·b15
    - b63·b60·b52·b45·b37, b33·b28·b21·b15·b9
    - b52·b45·b37·b33·b28·b21
  - g is computed combinationally from the current state, before the shift.
- Outputs:
  - Par_out = b; Ser_out = b[0].
  - Both are driven directly from the register, with no combinational path from any input.
  - Ser_out shows the bit that is being shifted out on the next enabled edge.
- Latency:
  - A load is visible on Par_out one cycle after the edge where Par_load is sampled high.
  - Each shift is visible one cycle after its edge.
- Boundaries:
  - All-zero state is a fixed point: g=0, so the state stays zero under shifting.
  - Reset mid-shift sequence clears the state on that edge; shifting resumes from zero.
  - Toggling shift_en low freezes the state exactly; there is no lost or duplicated step when it is reasserted.
  - Power-up state before the first reset is undefined (X); the bench must reset or load first.

Decomposition:
- Shared package nfsr_pkg:
  - NFSR_WIDTH = 80.
  - localparam tap indices for the linear and nonlinear terms.
  - A function nfsr_feedback(logic [79:0]) returning g.
- One natural sub-module: nfsr_feedback_logic (pure combinational g), instantiated by nfsr.
- The register and its priority mux stay in the nfsr top.

Test Plan:
- Reset: load Seed=80'h123456789ABCDEF01234, then pulse rst for one cycle -> Par_out=80'h0, Ser_out=0. Shifting 10 cycles keeps Par_out=0.
- Load and single-bit linear tap: Seed=80'h1, Par_load one cycle -> Par_out=80'h1, Ser_out=1.
  - One shift -> Par_out=80'h80000000000000000000.
  - Next shift -> 80'h40000000000000000000, Ser_out=0.
- Linear tap b9: Seed=80'h200, one shift -> Par_out=80'h80000000000000000100.
- Nonlinear cancellation: Seed=80'h00009000000000000000 (b63, b60 set), one shift -> g=1^1=0, Par_out=80'h00004800000000000000.
- Priority and hold:
  - Par_load=1 with shift_en=1 -> Par_out=Seed exactly (no shift).
  - rst=1 with Par_load=1 -> Par_out=0.
  - shift_en=0 for 2 cycles -> Par_out unchanged.
- Long run: Seed=80'h123456789ABCDEF01234, shift 10 cycles, pause 2 cycles, shift 5 more -> Par_out and Ser_out match a reference model of g cycle by cycle, with the state frozen during the pause.
